// File: rtl/alu_packet_sequencer.sv
// Byte-stream command sequencer between UART RX and TX: parses opcode/len header, accumulates ADD
// operands or echoes payload, and returns 4-byte results LSB first. Define ALU_MUL_EN to add OP_MUL.
module alu_packet_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [7:0]  OP_ECHO    = 8'hEC,
    parameter logic [7:0]  OP_ADD     = 8'h01,
    parameter logic [7:0]  OP_MUL     = 8'h02
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy_o,
    output logic                  drop_o
);

    localparam int unsigned ACC_W     = 32;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned IDX_W     = 2;
    localparam logic [LEN_W-1:0] HDR_BYTES = LEN_W'(4);
`ifdef ALU_MUL_EN
    localparam int unsigned MUL_CNT_W = 5;
    localparam bit          MUL_EN    = 1'b1;
`else
    localparam bit          MUL_EN    = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        HDR_RSV,
        HDR_LEN_L,
        HDR_LEN_H,
        PAYLOAD,
        MUL_BUSY,
        RESP,
        DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0]  len_lo_q, len_lo_d;
    logic [LEN_W-1:0]       rem_q, rem_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [ACC_W-1:0]       opnd_q, opnd_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       resp_idx_q, resp_idx_d;
    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   drop_q, drop_d;
    logic                   busy_q, busy_d;
    logic                   live_q;
`ifdef ALU_MUL_EN
    logic [ACC_W-1:0]       mcand_q, mcand_d;
    logic [ACC_W-1:0]       mplier_q, mplier_d;
    logic [ACC_W-1:0]       prod_q, prod_d;
    logic [ACC_W-1:0]       prod_nx_c;
    logic [MUL_CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
`endif

    logic                   s_ready_c;
    logic                   s_fire_c;
    logic                   is_add_c, is_mul_c, is_echo_c, is_known_c;
    logic [LEN_W-1:0]       len_c, rem_init_c;
    logic [ACC_W-1:0]       acc_init_c, word_c, sum_c;
    logic                   last_c, word_done_c;

    function automatic logic [DATA_WIDTH-1:0] byte_sel(input logic [ACC_W-1:0] w,
                                                       input logic [IDX_W-1:0] i);
        return DATA_WIDTH'(w >> {i, 3'b000});
    endfunction

    // Next-state, datapath and handshake decode
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        len_lo_d   = len_lo_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        idx_d      = idx_q;
        resp_idx_d = resp_idx_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        drop_d     = 1'b0;
`ifdef ALU_MUL_EN
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        prod_d     = prod_q;
        mul_cnt_d  = mul_cnt_q;
        prod_nx_c  = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

        is_add_c    = (opcode_q == OP_ADD);
        is_mul_c    = MUL_EN && (opcode_q == OP_MUL);
        is_echo_c   = (opcode_q == OP_ECHO);
        is_known_c  = is_add_c || is_mul_c || is_echo_c;
        acc_init_c  = is_mul_c ? ACC_W'(1) : '0;
        len_c       = LEN_W'({s_axis_tdata, len_lo_q});
        rem_init_c  = len_c - HDR_BYTES;
        word_c      = ((idx_q == '0) ? '0 : opnd_q) | (ACC_W'(s_axis_tdata) << {idx_q, 3'b000});
        sum_c       = acc_q + word_c;
        last_c      = (rem_q == LEN_W'(1));
        word_done_c = (idx_q == IDX_W'(3)) || last_c;

        // Echo is a single-entry pipeline; everything else only ever stalls on state
        s_ready_c = 1'b0;
        case (state_q)
            IDLE, HDR_RSV, HDR_LEN_L, HDR_LEN_H, DRAIN: s_ready_c = 1'b1;
            PAYLOAD: s_ready_c = is_echo_c ? ((rem_q != '0) && (!m_valid_q || m_axis_tready))
                                           : 1'b1;
            default: s_ready_c = 1'b0;
        endcase
        s_ready_c = s_ready_c && live_q;
        s_fire_c  = s_axis_tvalid && s_ready_c;

        case (state_q)
            IDLE: if (s_fire_c) begin
                opcode_d = s_axis_tdata;
                state_d  = HDR_RSV;
            end
            HDR_RSV: if (s_fire_c) state_d = HDR_LEN_L;
            HDR_LEN_L: if (s_fire_c) begin
                len_lo_d = s_axis_tdata;
                state_d  = HDR_LEN_H;
            end
            HDR_LEN_H: if (s_fire_c) begin
                rem_d = rem_init_c;
                idx_d = '0;
                if (len_c < HDR_BYTES) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end else if (!is_known_c) begin
                    drop_d  = (rem_init_c == '0);
                    state_d = (rem_init_c == '0) ? IDLE : DRAIN;
                end else if (is_echo_c) begin
                    state_d = (rem_init_c == '0) ? IDLE : PAYLOAD;
                end else begin
                    acc_d = acc_init_c;
                    if (rem_init_c == '0) begin
                        m_valid_d  = 1'b1;
                        m_data_d   = byte_sel(acc_init_c, '0);
                        resp_idx_d = '0;
                        state_d    = RESP;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: if (is_echo_c) begin
                if (s_fire_c) begin
                    m_data_d  = s_axis_tdata;
                    m_valid_d = 1'b1;
                    rem_d     = rem_q - LEN_W'(1);
                end else begin
                    if (m_axis_tready) m_valid_d = 1'b0;
                    if ((rem_q == '0) && (!m_valid_q || m_axis_tready)) state_d = IDLE;
                end
            end else if (s_fire_c) begin
                opnd_d = word_c;
                rem_d  = rem_q - LEN_W'(1);
                idx_d  = word_done_c ? '0 : idx_q + IDX_W'(1);
                if (word_done_c) begin
`ifdef ALU_MUL_EN
                    if (is_mul_c) begin
                        mcand_d   = acc_q;
                        mplier_d  = word_c;
                        prod_d    = '0;
                        mul_cnt_d = '0;
                        state_d   = MUL_BUSY;
                    end else
`endif
                    begin
                        acc_d = sum_c;
                        if (last_c) begin
                            m_valid_d  = 1'b1;
                            m_data_d   = byte_sel(sum_c, '0);
                            resp_idx_d = '0;
                            state_d    = RESP;
                        end
                    end
                end
            end
`ifdef ALU_MUL_EN
            // Shift-add: one multiplier bit per cycle, 32 cycles per operand
            MUL_BUSY: begin
                prod_d    = prod_nx_c;
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                mul_cnt_d = mul_cnt_q + MUL_CNT_W'(1);
                if (mul_cnt_q == '1) begin
                    acc_d = prod_nx_c;
                    if (rem_q == '0) begin
                        m_valid_d  = 1'b1;
                        m_data_d   = byte_sel(prod_nx_c, '0);
                        resp_idx_d = '0;
                        state_d    = RESP;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
`endif
            RESP: if (m_valid_q && m_axis_tready) begin
                if (resp_idx_q == IDX_W'(3)) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    resp_idx_d = resp_idx_q + IDX_W'(1);
                    m_data_d   = byte_sel(acc_q, resp_idx_q + IDX_W'(1));
                end
            end
            DRAIN: if (s_fire_c) begin
                rem_d = rem_q - LEN_W'(1);
                if (last_c) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            opcode_q   <= '0;
            len_lo_q   <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            idx_q      <= '0;
            resp_idx_q <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            drop_q     <= 1'b0;
            busy_q     <= 1'b0;
            live_q     <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q    <= '0;
            mplier_q   <= '0;
            prod_q     <= '0;
            mul_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            len_lo_q   <= len_lo_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            idx_q      <= idx_d;
            resp_idx_q <= resp_idx_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            drop_q     <= drop_d;
            busy_q     <= busy_d;
            live_q     <= 1'b1;
`ifdef ALU_MUL_EN
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            prod_q     <= prod_d;
            mul_cnt_q  <= mul_cnt_d;
`endif
        end
    end

    assign s_axis_tready = s_ready_c;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign busy_o        = busy_q;
    assign drop_o        = drop_q;

endmodule

// File: tb/tb_alu_packet_sequencer.sv
// Directed bench for alu_packet_sequencer: hand-computed TX bytes, drop pulses and reset behaviour.
`timescale 1ns/1ps
module tb_alu_packet_sequencer;

    logic       clk_i         = 1'b0;
    logic       rst_ni        = 1'b0;
    logic [7:0] s_axis_tdata  = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       busy_o;
    logic       drop_o;

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         drop_cnt   = 0;
    int         stall_cnt  = 0;
    bit         rdy_toggle = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic [7:0] rx_q[$];

    always #5 clk_i = ~clk_i;

    alu_packet_sequencer dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy_o        (busy_o),
        .drop_o        (drop_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Downstream ready: steady high, or alternating every cycle
    always @(negedge clk_i) m_axis_tready = rdy_toggle ? ~m_axis_tready : 1'b1;

    // TX capture, hold-while-stalled and drop pulse monitor
    always @(negedge clk_i) begin
        #1;
        if (rst_ni) begin
            if (prev_stall) check("tx_hold", 32'({m_axis_tvalid, m_axis_tdata}), 32'({1'b1, prev_data}));
            if (m_axis_tvalid && m_axis_tready) rx_q.push_back(m_axis_tdata);
            if (m_axis_tvalid && !m_axis_tready) stall_cnt++;
            if (drop_o) drop_cnt++;
        end
        prev_stall = rst_ni && m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        bit   done;
        done = 1'b0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            #1;
            rdy = s_axis_tready;
            @(negedge clk_i);
            done = rdy;
        end
        s_axis_tvalid = 1'b0;
        if (!done) check("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic send_pkt(input logic [7:0] pkt[$]);
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk_i);
            #2;
            k++;
        end
        if (rx_q.size() < n) check("tx_timeout", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp[$]);
        logic [31:0] got;
        wait_tx(exp.size(), 300);
        tick(4);
        check({tag, "_len"}, 32'(rx_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            got = 32'hFFFF_FFFF;
            if (i < rx_q.size()) got = 32'(rx_q[i]);
            check($sformatf("%s_b%0d", tag, i), got, 32'(exp[i]));
        end
        rx_q.delete();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pkt[$];
        logic [7:0] exp[$];
        int         exp_drop;

        // Reset values
        tick(3);
        #1;
        check("rst_s_ready", 32'(s_axis_tready), 32'(0));
        check("rst_m_valid", 32'(m_axis_tvalid), 32'(0));
        check("rst_m_data",  32'(m_axis_tdata),  32'(0));
        check("rst_busy",    32'(busy_o),        32'(0));
        check("rst_drop",    32'(drop_o),        32'(0));
        rst_ni = 1'b1;
        tick(2);
        #1;
        check("idle_ready", 32'(s_axis_tready), 32'(1));
        tick(1);

        // ADD 5 + 3
        pkt = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
        wait_tx(4, 100);
        @(negedge clk_i);
        #1;
        check("add_busy_after", 32'(busy_o), 32'(0));
        exp = '{8'h08, 8'h00, 8'h00, 8'h00};
        expect_tx("add", exp);

        // ADD wraps modulo 2^32
        pkt = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
        exp = '{8'h01, 8'h00, 8'h00, 8'h00};
        expect_tx("wrap", exp);

        // ADD with empty payload returns zero
        pkt = '{8'h01, 8'h00, 8'h04, 8'h00};
        send_pkt(pkt);
        exp = '{8'h00, 8'h00, 8'h00, 8'h00};
        expect_tx("add_empty", exp);

        // ECHO with downstream stalls
        stall_cnt  = 0;
        rdy_toggle = 1'b1;
        pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_pkt(pkt);
        exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        expect_tx("echo", exp);
        rdy_toggle = 1'b0;
        tick(2);
        check("echo_stalled", 32'(stall_cnt != 0), 32'(1));
        check("echo_busy", 32'(busy_o), 32'(0));

        // ECHO with empty payload: nothing sent, no drop
        drop_cnt = 0;
        pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
        send_pkt(pkt);
        exp.delete();
        expect_tx("echo_empty", exp);
        check("echo_empty_drop", 32'(drop_cnt), 32'(0));

        // Malformed length, then recovery
        drop_cnt = 0;
        pkt = '{8'h01, 8'h00, 8'h03, 8'h00};
        send_pkt(pkt);
        exp.delete();
        expect_tx("short", exp);
        check("short_drop", 32'(drop_cnt), 32'(1));
        pkt = '{8'h01, 8'h00, 8'h08, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
        exp = '{8'h2A, 8'h00, 8'h00, 8'h00};
        expect_tx("recover", exp);

        // Unknown opcode drained; drop only after final byte
        drop_cnt = 0;
        pkt = '{8'h7F, 8'h00, 8'h06, 8'h00, 8'hAA};
        send_pkt(pkt);
        tick(3);
        check("drain_early_drop", 32'(drop_cnt), 32'(0));
        send_byte(8'hBB);
        tick(3);
        check("drain_drop", 32'(drop_cnt), 32'(1));
        exp.delete();
        expect_tx("drain", exp);
        check("drain_busy", 32'(busy_o), 32'(0));

        // Reset mid-packet
        pkt = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00};
        send_pkt(pkt);
        rst_ni = 1'b0;
        @(negedge clk_i);
        #1;
        check("mid_rst_s_ready", 32'(s_axis_tready), 32'(0));
        check("mid_rst_m_valid", 32'(m_axis_tvalid), 32'(0));
        check("mid_rst_m_data",  32'(m_axis_tdata),  32'(0));
        check("mid_rst_busy",    32'(busy_o),        32'(0));
        check("mid_rst_drop",    32'(drop_o),        32'(0));
        rst_ni = 1'b1;
        tick(2);
        pkt = '{8'h01, 8'h00, 8'h08, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
        exp = '{8'h10, 8'h00, 8'h00, 8'h00};
        expect_tx("post_rst", exp);

        // Multiply 7 * 6, or unknown opcode without the multiplier
        drop_cnt = 0;
        pkt = '{8'h02, 8'h00, 8'h0C, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
`ifdef ALU_MUL_EN
        exp      = '{8'h2A, 8'h00, 8'h00, 8'h00};
        exp_drop = 0;
`else
        exp.delete();
        exp_drop = 1;
`endif
        expect_tx("mul", exp);
        check("mul_drop", 32'(drop_cnt), 32'(exp_drop));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
